// File: rtl/ccu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ccu_sequencer
// Purpose  : Microcoded control sequencer. Fetches 24-bit instructions from a
//            program ROM and drives DPU register selects / opcode, a
//            load-immediate path, and a video plot handshake.
// Ports    : clk, rst_n (async, active-low)
//            start                 - begin execution at address 0 when idle
//            instr_addr/instr_data - program ROM address / word
//            a_sel,b_sel,r_sel     - DPU operand and result register indices
//            n_op, m_data          - DPU opcode and load-immediate data
//            cc_in                 - DPU condition codes (bit 0 = zero)
//            out_enable            - toggles once per completed plot
//            vid_valid/vid_ready   - plot handshake
//            busy, done            - run status, one-cycle halt pulse
// Revision : 1.0 - initial release
// ============================================================================
module ccu_sequencer #(
  parameter int PC_W    = 8,
  parameter int SCRATCH = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [23:0]     instr_data,
  output logic [3:0]      a_sel,
  output logic [3:0]      b_sel,
  output logic [3:0]      r_sel,
  output logic [3:0]      n_op,
  output logic [7:0]      m_data,
  input  logic [3:0]      cc_in,
  output logic            out_enable,
  output logic            vid_valid,
  input  logic            vid_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_issue  = 3'd2;
  localparam logic [2:0] c_st_settle = 3'd3;
  localparam logic [2:0] c_st_plot   = 3'd4;

  localparam logic [3:0] c_cls_alu  = 4'd0;
  localparam logic [3:0] c_cls_load = 4'd1;
  localparam logic [3:0] c_cls_plot = 4'd2;
  localparam logic [3:0] c_cls_brz  = 4'd3;
  localparam logic [3:0] c_cls_jmp  = 4'd4;
  localparam logic [3:0] c_cls_halt = 4'd15;
  localparam logic [3:0] c_op_load  = 4'd8;
  localparam logic [3:0] c_scratch  = 4'(SCRATCH);

  logic [2:0]      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic [23:0]     r_ir, w_ir_nxt;
  logic            r_zflag, w_zflag_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_vid_valid, w_vid_valid_nxt;
  logic            r_out_enable, w_out_enable_nxt;
  logic [3:0]      r_a_sel, r_b_sel, r_r_sel, r_n_op;
  logic [3:0]      w_a_sel_nxt, w_b_sel_nxt, w_r_sel_nxt, w_n_op_nxt;
  logic [7:0]      r_m_data, w_m_data_nxt;

  // Decode of the word arriving in FETCH (drives the registered issue
  // outputs) and of the latched word used during ISSUE/SETTLE.
  logic [3:0] w_f_cls, w_f_n, w_i_cls, w_i_n;
  logic       w_f_load, w_f_alu, w_i_alu_grp, w_i_alu;
  logic       w_unused;

  assign w_f_cls     = instr_data[23:20];
  assign w_f_n       = instr_data[19:16];
  // An ALU word carrying the load opcode behaves exactly like LOAD.
  assign w_f_load    = (w_f_cls == c_cls_load) || (w_f_cls == c_cls_alu && w_f_n == c_op_load);
  assign w_f_alu     = (w_f_cls == c_cls_alu) && (w_f_n != c_op_load);
  assign w_i_cls     = r_ir[23:20];
  assign w_i_n       = r_ir[19:16];
  assign w_i_alu_grp = (w_i_cls == c_cls_alu) || (w_i_cls == c_cls_load);
  assign w_i_alu     = (w_i_cls == c_cls_alu) && (w_i_n != c_op_load);
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_target    = r_ir[PC_W-1:0];
  assign w_unused    = ^{cc_in[3:1], r_ir};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_pc         <= '0;
      r_ir         <= '0;
      r_zflag      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_out_enable <= 1'b0;
      r_a_sel      <= c_scratch;
      r_b_sel      <= c_scratch;
      r_r_sel      <= c_scratch;
      r_n_op       <= 4'd0;
      r_m_data     <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_zflag      <= w_zflag_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_vid_valid  <= w_vid_valid_nxt;
      r_out_enable <= w_out_enable_nxt;
      r_a_sel      <= w_a_sel_nxt;
      r_b_sel      <= w_b_sel_nxt;
      r_r_sel      <= w_r_sel_nxt;
      r_n_op       <= w_n_op_nxt;
      r_m_data     <= w_m_data_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (start) w_state_nxt = c_st_fetch;
      c_st_fetch:  w_state_nxt = c_st_issue;
      c_st_issue: begin
        if (w_i_alu_grp)                w_state_nxt = c_st_settle;
        else if (w_i_cls == c_cls_plot) w_state_nxt = c_st_plot;
        else if (w_i_cls == c_cls_halt) w_state_nxt = c_st_idle;
        else                            w_state_nxt = c_st_fetch;
      end
      c_st_settle: w_state_nxt = c_st_fetch;
      c_st_plot:   if (vid_ready) w_state_nxt = c_st_fetch;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Next values of the registered outputs and datapath. Register selects
  // fall back to the scratch index every cycle unless explicitly driven or
  // held, so no user register is written outside ALU/LOAD issue.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ir_nxt         = r_ir;
    w_zflag_nxt      = r_zflag;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_vid_valid_nxt  = r_vid_valid;
    w_out_enable_nxt = r_out_enable;
    w_a_sel_nxt      = c_scratch;
    w_b_sel_nxt      = c_scratch;
    w_r_sel_nxt      = c_scratch;
    w_n_op_nxt       = 4'd0;
    w_m_data_nxt     = 8'd0;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_pc_nxt   = '0;
          w_busy_nxt = 1'b1;
        end
      end
      c_st_fetch: begin
        w_ir_nxt = instr_data;
        if (w_f_load) begin
          w_n_op_nxt   = c_op_load;
          w_r_sel_nxt  = instr_data[7:4];
          w_m_data_nxt = instr_data[15:8];
        end else if (w_f_alu) begin
          w_n_op_nxt  = w_f_n;
          w_a_sel_nxt = instr_data[15:12];
          w_b_sel_nxt = instr_data[11:8];
          w_r_sel_nxt = instr_data[7:4];
        end
      end
      c_st_issue: begin
        if (w_i_alu_grp) begin
          // Hold the issued operation through SETTLE.
          w_n_op_nxt   = r_n_op;
          w_a_sel_nxt  = r_a_sel;
          w_b_sel_nxt  = r_b_sel;
          w_r_sel_nxt  = r_r_sel;
          w_m_data_nxt = r_m_data;
        end else if (w_i_cls == c_cls_plot) begin
          w_vid_valid_nxt = 1'b1;
        end else if (w_i_cls == c_cls_brz) begin
          w_pc_nxt = r_zflag ? w_target : w_pc_inc;
        end else if (w_i_cls == c_cls_jmp) begin
          w_pc_nxt = w_target;
        end else if (w_i_cls == c_cls_halt) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      c_st_settle: begin
        w_pc_nxt = w_pc_inc;
        if (w_i_alu) w_zflag_nxt = cc_in[0];
      end
      c_st_plot: begin
        if (vid_ready) begin
          w_vid_valid_nxt  = 1'b0;
          w_out_enable_nxt = ~r_out_enable;
          w_pc_nxt         = w_pc_inc;
        end
      end
      default: ;
    endcase
  end

  assign instr_addr = r_pc;
  assign a_sel      = r_a_sel;
  assign b_sel      = r_b_sel;
  assign r_sel      = r_r_sel;
  assign n_op       = r_n_op;
  assign m_data     = r_m_data;
  assign out_enable = r_out_enable;
  assign vid_valid  = r_vid_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ccu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccu_sequencer
// Purpose  : Self-checking bench for ccu_sequencer. An instruction-level
//            interpreter expands each program into the expected per-cycle
//            output trace together with the per-cycle input stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  instr_addr;
  logic [23:0] instr_data;
  logic [3:0]  a_sel, b_sel, r_sel, n_op;
  logic [7:0]  m_data;
  logic [3:0]  cc_in;
  logic        out_enable, vid_valid, vid_ready, busy, done;

  logic [23:0] rom [0:255];
  // ROM word settles within the cycle its address is presented.
  assign instr_data = rom[instr_addr];

  ccu_sequencer #(.PC_W(8), .SCRATCH(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .a_sel(a_sel), .b_sel(b_sel), .r_sel(r_sel), .n_op(n_op), .m_data(m_data),
    .cc_in(cc_in), .out_enable(out_enable),
    .vid_valid(vid_valid), .vid_ready(vid_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] a, b, r, n;
    logic [7:0] m;
    logic       vv, oe, busy, done;
    logic [3:0] cc;
    logic       rdy, st;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic m_z, m_oe;
  int   alu_cnt;
  bit   alt_mode;
  int   plot_wait_fixed;
  int   vv_cnt, oe_tog, addr_chg;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic cyc_t idle_cyc(input logic [7:0] addr);
    cyc_t c;
    c.addr = addr; c.a = 4'hF; c.b = 4'hF; c.r = 4'hF; c.n = 4'h0; c.m = 8'h00;
    c.vv = 1'b0; c.oe = m_oe; c.busy = 1'b1; c.done = 1'b0;
    c.cc = 4'($urandom); c.rdy = 1'($urandom); c.st = 1'($urandom);
    return c;
  endfunction

  // Instruction-level interpreter: one iteration per executed instruction.
  task automatic build_model();
    logic [7:0]  pc;
    logic [23:0] ins;
    logic [3:0]  cls, n;
    bit          halted;
    cyc_t        e;
    int          w;
    exp_q.delete();
    pc = 8'h00; halted = 0; alu_cnt = 0;
    while (!halted && exp_q.size() < 3000) begin
      ins = rom[pc]; cls = ins[23:20]; n = ins[19:16];
      exp_q.push_back(idle_cyc(pc));                      // fetch
      if (cls == 4'd1 || (cls == 4'd0 && n == 4'd8)) begin
        for (int k = 0; k < 2; k++) begin
          e = idle_cyc(pc); e.r = ins[7:4]; e.n = 4'd8; e.m = ins[15:8];
          exp_q.push_back(e);
        end
        pc = pc + 8'd1;
      end else if (cls == 4'd0) begin
        for (int k = 0; k < 2; k++) begin
          e = idle_cyc(pc); e.a = ins[15:12]; e.b = ins[11:8]; e.r = ins[7:4]; e.n = n;
          if (k == 1) begin
            if (alt_mode) e.cc[0] = alu_cnt[0];
            m_z = e.cc[0];
          end
          exp_q.push_back(e);
        end
        alu_cnt++;
        pc = pc + 8'd1;
      end else if (cls == 4'd2) begin
        exp_q.push_back(idle_cyc(pc));
        w = (plot_wait_fixed >= 0) ? plot_wait_fixed : int'($urandom_range(0, 4));
        for (int k = 0; k <= w; k++) begin
          e = idle_cyc(pc); e.vv = 1'b1; e.rdy = (k == w);
          exp_q.push_back(e);
        end
        m_oe = ~m_oe;
        pc = pc + 8'd1;
      end else if (cls == 4'd3) begin
        exp_q.push_back(idle_cyc(pc));
        pc = m_z ? ins[7:0] : pc + 8'd1;
      end else if (cls == 4'd4) begin
        exp_q.push_back(idle_cyc(pc));
        pc = ins[7:0];
      end else if (cls == 4'd15) begin
        exp_q.push_back(idle_cyc(pc));
        e = idle_cyc(pc); e.busy = 1'b0; e.done = 1'b1; e.st = 1'b0;
        exp_q.push_back(e);
        e = idle_cyc(pc); e.busy = 1'b0; e.st = 1'b0;
        exp_q.push_back(e);
        halted = 1;
      end else begin
        exp_q.push_back(idle_cyc(pc));
        pc = pc + 8'd1;
      end
    end
  endtask

  task automatic apply_reset(input bit with_checks);
    #2 rst_n = 1'b0;
    #1;
    if (with_checks) begin
      check_val("rst_vid_valid", vid_valid, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_outs", {instr_addr, out_enable, n_op, r_sel, m_data},
                {8'h00, 1'b0, 4'h0, 4'hF, 8'h00});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    m_z = 1'b0; m_oe = 1'b0;
  endtask

  task automatic run_prog(input bit abort_plot);
    cyc_t       e;
    logic [39:0] obs, expv;
    logic       prev_oe;
    logic [7:0] prev_addr;
    int         fails0;
    build_model();
    vv_cnt = 0; oe_tog = 0; addr_chg = 0;
    prev_oe = out_enable; prev_addr = instr_addr;
    fails0 = n_checks - n_pass;
    start = 1'b1;
    @(posedge clk); #1;
    foreach (exp_q[i]) begin
      e = exp_q[i];
      obs  = {instr_addr, a_sel, b_sel, r_sel, n_op, m_data, vid_valid, out_enable, busy, done};
      expv = {e.addr, e.a, e.b, e.r, e.n, e.m, e.vv, e.oe, e.busy, e.done};
      check_val($sformatf("cyc%0d", i), obs, expv);
      if (vid_valid) begin
        vv_cnt++;
        if (instr_addr != prev_addr) addr_chg++;
      end
      if (out_enable != prev_oe) oe_tog++;
      prev_oe = out_enable; prev_addr = instr_addr;
      if (abort_plot && e.vv) begin
        apply_reset(1'b1);
        return;
      end
      if ((n_checks - n_pass) != fails0) begin
        apply_reset(1'b0);                 // resynchronise after a mismatch
        return;
      end
      start = e.st; cc_in = e.cc; vid_ready = e.rdy;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'hF00000;
  endtask

  task automatic gen_random_prog();
    int          len, sel;
    logic [23:0] ins;
    clear_rom();
    len = $urandom_range(4, 12);
    for (int i = 0; i < len - 1; i++) begin
      ins = 24'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: ins[23:20] = 4'd0;
        2, 3:    ins[23:20] = 4'd1;
        4:       ins[23:20] = 4'd2;
        5:       ins[23:20] = 4'd3;
        6:       ins[23:20] = 4'd4;
        7:       ins[23:20] = 4'($urandom_range(5, 14));
        default: begin ins[23:20] = 4'd0; ins[19:16] = 4'd8; end
      endcase
      // Forward-only branch targets keep every program terminating.
      if (ins[23:20] == 4'd3 || ins[23:20] == 4'd4)
        ins[7:0] = 8'($urandom_range(i + 1, len - 1));
      rom[i] = ins;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cc_in = 4'h0; vid_ready = 1'b0;
    plot_wait_fixed = -1; alt_mode = 0; m_z = 1'b0; m_oe = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk); #1;
    check_val("reset_state",
              {instr_addr, a_sel, b_sel, r_sel, n_op, m_data, vid_valid, out_enable, busy, done},
              {8'h00, 4'hF, 4'hF, 4'hF, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_val("idle_after_release", {instr_addr, busy, done, n_op}, {8'h00, 1'b0, 1'b0, 4'h0});

    // Two loads then halt.
    rom[0] = 24'h101290; rom[1] = 24'h1034A0;
    run_prog(1'b0);
    check_val("busy_after_halt", busy, 1'b0);

    // ALU/BRZ both ways plus jump to the last address and wrap to 0.
    clear_rom();
    rom[0] = 24'h012340; rom[1] = 24'h300020; rom[2] = 24'h4000FF;
    rom[8'h20] = 24'hF00000; rom[8'hFF] = 24'h500000;
    alt_mode = 1;
    run_prog(1'b0);
    alt_mode = 0;
    check_val("wrap_halt_addr", instr_addr, 8'h20);

    // Plot held off for five cycles.
    clear_rom();
    rom[0] = 24'h200000;
    plot_wait_fixed = 5;
    run_prog(1'b0);
    check_val("plot_vv_cycles", vv_cnt, 6);
    check_val("plot_oe_toggles", oe_tog, 1);
    check_val("plot_no_fetch", addr_chg, 0);

    // Reset in the middle of a plot wait, then re-run from address 0.
    run_prog(1'b1);
    plot_wait_fixed = -1;
    repeat (3) @(posedge clk); #1;
    check_val("idle_after_abort", {busy, vid_valid, instr_addr}, {1'b0, 1'b0, 8'h00});
    clear_rom();
    rom[0] = 24'h101290; rom[1] = 24'h200000;
    run_prog(1'b0);

    for (int p = 0; p < 20; p++) begin
      gen_random_prog();
      run_prog(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
